// File: rtl/truth_table_sweeper_pkg.sv
// Shared encodings and sizing for the truth-table sweeper and its settle timer.
package sweeper_pkg;

  localparam int IDX_W      = 3;
  localparam int NVEC       = 8;
  localparam int CNT_W      = 4;
  localparam int SETTLE_MAX = 15;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // The settle parameter must fit the 4-bit timer and cannot be zero.
  function automatic int clamp_settle(input int settle);
    if (settle < 1)          return 1;
    if (settle > SETTLE_MAX) return SETTLE_MAX;
    return settle;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable 4-bit down-counter that measures how long a vector is held.
module settle_timer
  import sweeper_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps {x1,x2,x3} through 0..7, samples f_in after each settle window and
// compares the assembled truth table with a reference captured at start.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       f_in,
  output logic       x1,
  output logic       x2,
  output logic       x3,
  output logic [7:0] table_out,
  output logic       busy,
  output logic       done,
  output logic       match
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(clamp_settle(SETTLE) - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NVEC - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] x_q;
  logic [NVEC-1:0]  table_q;
  logic [NVEC-1:0]  table_d;
  logic [NVEC-1:0]  expected_q;
  logic             busy_q;
  logic             done_q;
  logic             match_q;

  logic accept;
  logic last_vec;
  logic timer_load;
  logic timer_zero;

  assign accept     = (state_q == S_IDLE) && start;
  assign last_vec   = (idx_q == LAST_IDX);
  assign timer_load = accept || ((state_q == S_SAMPLE) && !last_vec);

  settle_timer u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (state_q == S_DRIVE),
    .zero_o     (timer_zero)
  );

  // Table as it will look after the current SAMPLE cycle; the final compare
  // uses it so match is already valid in the DONE cycle.
  always_comb begin
    // NOTE: default first so every path assigns table_d and no latch is inferred.
    table_d        = table_q;
    table_d[idx_q] = f_in;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking everywhere here so all registers update from pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      x_q        <= '0;
      table_q    <= '0;
      expected_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_DRIVE;
            idx_q      <= '0;
            x_q        <= '0;
            table_q    <= '0;
            expected_q <= expected;
            match_q    <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_DRIVE: begin
          if (timer_zero) state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          table_q <= table_d;
          if (!last_vec) begin
            state_q <= S_DRIVE;
            idx_q   <= idx_q + 3'd1;
            x_q     <= idx_q + 3'd1;
          end else begin
            state_q <= S_DONE;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            match_q <= (table_d == expected_q);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          match_q <= (table_q == expected_q);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x1        = x_q[2];
  assign x2        = x_q[1];
  assign x3        = x_q[0];
  assign table_out = table_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign match     = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: three sweepers (SETTLE 2, 1, 15) each driving a parity/AND stub.
module tb_truth_table_sweeper;
  import sweeper_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       and_mode;
  logic       start_v  [3];
  logic [7:0] exp_v    [3];
  logic       f_v      [3];
  logic       x1_v     [3];
  logic       x2_v     [3];
  logic       x3_v     [3];
  logic [7:0] tab_v    [3];
  logic       busy_v   [3];
  logic       done_v   [3];
  logic       match_v  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_stub
    assign f_v[g] = and_mode ? (x1_v[g] & x2_v[g] & x3_v[g])
                             : (x1_v[g] ^ x2_v[g] ^ x3_v[g]);
  end

  truth_table_sweeper #(.SETTLE(2)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .expected(exp_v[0]), .f_in(f_v[0]),
    .x1(x1_v[0]), .x2(x2_v[0]), .x3(x3_v[0]), .table_out(tab_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .match(match_v[0]));

  truth_table_sweeper #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .expected(exp_v[1]), .f_in(f_v[1]),
    .x1(x1_v[1]), .x2(x2_v[1]), .x3(x3_v[1]), .table_out(tab_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .match(match_v[1]));

  truth_table_sweeper #(.SETTLE(15)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .expected(exp_v[2]), .f_in(f_v[2]),
    .x1(x1_v[2]), .x2(x2_v[2]), .x3(x3_v[2]), .table_out(tab_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .match(match_v[2]));

  typedef struct {
    int         dut;
    logic       and_m;
    logic [7:0] exp_in;
    logic [7:0] exp_tab;
    logic       exp_match;
  } vec_t;

  vec_t vecs [6];

  function automatic int settle_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 15;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full sweep on DUT d; observation index n counts edges after the accept edge.
  task automatic run_sweep(input int d, input logic [7:0] exp_in, input logic [7:0] exp_tab,
                           input logic exp_match, input string name);
    int   s1      = settle_of(d) + 1;
    int   lat     = 8 * s1;
    int   done_at = -1;
    int   dones   = 0;
    int   bad     = 0;
    int   cv;
    logic [7:0] mask;
    logic [2:0] xv;
    @(negedge clk);
    exp_v[d]   = exp_in;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    check({name, "_accept"}, {23'd0, tab_v[d], match_v[d]}, 32'd0);
    for (int n = 0; n <= lat + 3; n++) begin
      if (n > 0) @(negedge clk);
      if (n < lat) begin
        cv   = n / s1;
        mask = 8'((1 << cv) - 1);
        xv   = 3'(cv);
        if ({x1_v[d], x2_v[d], x3_v[d]} !== xv || busy_v[d] !== 1'b1 ||
            done_v[d] !== 1'b0 || tab_v[d] !== (exp_tab & mask))
          bad++;
      end
      if (done_v[d] === 1'b1) begin
        dones++;
        if (done_at < 0) done_at = n;
        check({name, "_done_match"}, {31'd0, match_v[d]}, {31'd0, exp_match});
        check({name, "_done_busy"}, {31'd0, busy_v[d]}, 32'd0);
      end
    end
    check({name, "_trace"}, bad, 0);
    check({name, "_done_cycle"}, done_at + 1, lat + 1);
    check({name, "_done_count"}, dones, 1);
    check({name, "_table"}, {24'd0, tab_v[d]}, {24'd0, exp_tab});
    check({name, "_match_held"}, {31'd0, match_v[d]}, {31'd0, exp_match});
    check({name, "_idle_x"}, {29'd0, x1_v[d], x2_v[d], x3_v[d]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         dones;
    int         dt [$];
    logic       bh [0:127];
    int         period;

    vecs[0] = '{0, 1'b0, 8'h96, 8'h96, 1'b1};
    vecs[1] = '{0, 1'b1, 8'h96, 8'h80, 1'b0};
    vecs[2] = '{1, 1'b0, 8'h96, 8'h96, 1'b1};
    vecs[3] = '{2, 1'b0, 8'h96, 8'h96, 1'b1};
    vecs[4] = '{0, 1'b1, 8'h80, 8'h80, 1'b1};
    vecs[5] = '{0, 1'b0, 8'h69, 8'h96, 1'b0};

    rst      = 1'b1;
    and_mode = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 1'b0;
      exp_v[d]   = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("reset_outputs_dut%0d", d),
            {18'd0, x1_v[d], x2_v[d], x3_v[d], tab_v[d], busy_v[d], done_v[d], match_v[d]}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      and_mode = vecs[i].and_m;
      run_sweep(vecs[i].dut, vecs[i].exp_in, vecs[i].exp_tab, vecs[i].exp_match,
                $sformatf("vec%0d", i));
    end
    and_mode = 1'b0;

    // Reset during vector 4 DRIVE (edge 12 after accept for SETTLE=2).
    @(negedge clk);
    exp_v[0]   = 8'h96;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_pre_x", {29'd0, x1_v[0], x2_v[0], x3_v[0]}, 32'd4);
    check("midrst_pre_table", {24'd0, tab_v[0]}, 32'h06);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs",
          {18'd0, x1_v[0], x2_v[0], x3_v[0], tab_v[0], busy_v[0], done_v[0], match_v[0]}, 32'd0);
    check("midrst_state", 32'(dut0.state_q), 32'(S_IDLE));
    rst = 1'b0;
    run_sweep(0, 8'h96, 8'h96, 1'b1, "post_rst");

    // Start pulses during a sweep are neither accepted nor queued.
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    dones = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start_v[0] = (n == 4 || n == 23);
      if (done_v[0] === 1'b1) dones++;
    end
    start_v[0] = 1'b0;
    check("ignore_done_count", dones, 1);
    check("ignore_busy_after", {31'd0, busy_v[0]}, 32'd0);
    check("ignore_table", {24'd0, tab_v[0]}, 32'h96);

    // Start held high: back-to-back sweeps.
    @(negedge clk);
    start_v[0] = 1'b1;
    for (int t = 0; t < 128; t++) begin
      @(negedge clk);
      bh[t] = busy_v[0];
      if (done_v[0] === 1'b1) dt.push_back(t);
    end
    start_v[0] = 1'b0;
    period = 8 * (settle_of(0) + 1) + 2;
    check("hold_done_count", (dt.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
    if (dt.size() >= 3) begin
      check("hold_period_1", dt[1] - dt[0], period);
      check("hold_period_2", dt[2] - dt[1], period);
      check("hold_idle_gap", {31'd0, bh[dt[0] + 1]}, 32'd0);
      check("hold_rebusy", {31'd0, bh[dt[0] + 2]}, 32'd1);
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
